sad_engine: RTL and testbench
=============================

# sad_engine

Sum-of-absolute-differences engine that sits directly downstream of the SAD register bank. It consumes the 16 window words and 16 frame words the bank presents, snapshots them on a start request, and accumulates |window − frame| over several cycles. It reports each job's SAD and keeps a running best (minimum) SAD together with the caller-supplied search position, for use by the motion-search controller.

## Interface
- LANES, 4, number of element differences summed per cycle; legal values 1, 2, 4, 8, 16 (C = 16/LANES accumulate cycles)
- Clk  input  1  clock; all state updates on posedge
- Reset  input  1  reset Reset, synchronous, active-high
- Start  input  1  job request; accepted only when Busy=0
- Position  input  16  search-position tag; captured with the operands on an accepted Start
- ClearBest  input  1  synchronous clear of best-match tracking
- Window0..Window15  input  32 each  window words from the register bank, unsigned
- Frame0..Frame15  input  32 each  frame words from the register bank, unsigned
- Busy  output  1  job in progress; Start is ignored while high
- Done  output  1  one-cycle pulse: SadValue is valid for the finished job
- SadValue  output  36  SAD of the most recent finished job, held until the next Done
- BestSad  output  36  minimum SAD since the last Reset or ClearBest
- BestPos  output  16  Position tag of BestSad
- BestValid  output  1  BestSad/BestPos hold at least one result

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE: Start=1 at an edge → snapshot all 32 operands and Position into internal registers, clear the accumulator and element index, go to ACCUM, set Busy=1.
- ACCUM: each edge adds |Wi − Fi| for i = idx..idx+LANES−1 to the accumulator and advances idx by LANES. After C edges, load SadValue, go to DONE, drop Busy, and assert Done.
- DONE: lasts one cycle. Done=1 and Busy=0. On the next edge go to IDLE; a Start sampled at that edge is accepted, so jobs can run back-to-back.
- Arithmetic: operands are unsigned 32-bit. Each difference is computed at 33 bits and its magnitude taken, giving a 32-bit result. Accumulate at 36 bits; overflow is impossible because the maximum is 16·(2^32−1).
- Snapshot: after acceptance, changes on Window/Frame/Position do not affect the running job. The bank may be rewritten (negedge writes) while Busy=1.
- Best tracking, applied at the edge that loads SadValue:
  - If BestValid=0, or the new SAD is strictly less than BestSad, then BestSad←SadValue, BestPos←captured Position, BestValid←1.
  - Ties keep the earlier entry.
- ClearBest alone: BestSad←36'hF_FFFF_FFFF, BestPos←0, BestValid←0.
- ClearBest on the same edge as a result: the clear applies first, then the result is recorded as the new best (BestValid=1).
- Start while Busy=1: ignored, with no queuing.
- Start and ClearBest together in IDLE: both take effect.

## Timing
- Reset values: state IDLE, Busy 0, Done 0, SadValue 0, BestSad 36'hF_FFFF_FFFF, BestPos 0, BestValid 0. The internal snapshot and accumulator clear to 0.
- Start sampled at edge k:
  - Busy=1 after edge k.
  - Result loaded, Done=1, Busy=0 after edge k+C; Done lasts exactly one cycle.
  - Latency is C cycles. Minimum start-to-start spacing is C+1 cycles.
- BestSad/BestPos/BestValid update at edge k+C, the same edge as SadValue.
- Reset asserted mid-job: the job aborts, no Done is issued, and all outputs take their reset values at that edge. Reset has priority over Start and ClearBest.
- Operands from the bank (written on negedge) are stable at the following posedge. Start may be issued in the cycle after a bank write.

## Test plan
- Basic job, LANES=4: Window all 5, Frame all 3, Start with Position=7 → Done exactly 4 cycles after Start, SadValue=32, BestSad=32, BestPos=7, BestValid=1.
- Width and sign:
  - Window all 32'hFFFF_FFFF, Frame all 0 → SadValue=36'hF_FFFF_FFF0.
  - Swapped operands give the same value.
  - Mixed pairs (10,3),(3,10),(0,0)… → SadValue=14.
- Best tracking: four jobs with SADs 100(pos 1), 40(pos 2), 40(pos 3), 90(pos 4) → BestSad=40, BestPos=2. Then ClearBest → BestValid=0, BestSad=all ones.
- Snapshot and busy:
  - Change Window/Frame and Position in the cycle after Start → result and BestPos reflect the sampled values.
  - A second Start while Busy=1 → no extra Done.
  - Start during the Done cycle → accepted.
- Reset and collisions:
  - Reset at the 2nd ACCUM cycle → no Done, outputs at reset values.
  - ClearBest on the Done edge with SAD=55, pos 9 → BestSad=55, BestPos=9, BestValid=1.
- LANES=1 and LANES=16 builds: same operands give the same SadValue, with Done latency of 16 and 1 cycles respectively.

Source files
------------

// File: rtl/sad_engine.sv
// sad_engine
// Sum-of-absolute-differences engine fed by the SAD register bank. On an
// accepted Start it snapshots the 16 window words, the 16 frame words and the
// Position tag, then sums |window - frame| over 16/LANES cycles. Each job
// reports its SAD on a one-cycle Done pulse. The block also keeps the smallest
// SAD seen so far, together with its Position tag, for the motion-search
// controller.
//
// Ports
//   Clk                 clock, all state changes on posedge
//   Reset               synchronous, active-high reset
//   Start               job request, accepted only while Busy=0
//   Position[15:0]      search-position tag, captured with the operands
//   ClearBest           synchronous clear of best-match tracking
//   Window0..15[31:0]   unsigned window words from the register bank
//   Frame0..15[31:0]    unsigned frame words from the register bank
//   Busy                job in progress
//   Done                one-cycle pulse, SadValue valid for the finished job
//   SadValue[35:0]      SAD of the most recent finished job
//   BestSad[35:0]       minimum SAD since Reset/ClearBest
//   BestPos[15:0]       Position tag of BestSad
//   BestValid           BestSad/BestPos hold at least one result
//
// LANES must divide 16 (1, 2, 4, 8 or 16).

module sad_engine #(
  parameter int LANES = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] Position,
  input  logic        ClearBest,
  input  logic [31:0] Window0,  input logic [31:0] Window1,
  input  logic [31:0] Window2,  input logic [31:0] Window3,
  input  logic [31:0] Window4,  input logic [31:0] Window5,
  input  logic [31:0] Window6,  input logic [31:0] Window7,
  input  logic [31:0] Window8,  input logic [31:0] Window9,
  input  logic [31:0] Window10, input logic [31:0] Window11,
  input  logic [31:0] Window12, input logic [31:0] Window13,
  input  logic [31:0] Window14, input logic [31:0] Window15,
  input  logic [31:0] Frame0,   input logic [31:0] Frame1,
  input  logic [31:0] Frame2,   input logic [31:0] Frame3,
  input  logic [31:0] Frame4,   input logic [31:0] Frame5,
  input  logic [31:0] Frame6,   input logic [31:0] Frame7,
  input  logic [31:0] Frame8,   input logic [31:0] Frame9,
  input  logic [31:0] Frame10,  input logic [31:0] Frame11,
  input  logic [31:0] Frame12,  input logic [31:0] Frame13,
  input  logic [31:0] Frame14,  input logic [31:0] Frame15,
  output logic        Busy,
  output logic        Done,
  output logic [35:0] SadValue,
  output logic [35:0] BestSad,
  output logic [15:0] BestPos,
  output logic        BestValid
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Element index step per cycle and the index of the last lane group.
  // With LANES=16 the step wraps to 0, which is harmless because the
  // single accumulate cycle is also the last one.
  localparam logic [3:0] STEP     = 4'(LANES);
  localparam logic [3:0] LAST_IDX = 4'(16 - LANES);
  localparam logic [35:0] SAD_MAX = 36'hF_FFFF_FFFF;

  // |a - b| of two unsigned words. Comparing first is equivalent to taking
  // the magnitude of the 33-bit signed difference and always fits 32 bits.
  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    if (a >= b) begin
      return a - b;
    end else begin
      return b - a;
    end
  endfunction

  logic [31:0] window_s [16];
  logic [31:0] frame_s  [16];
  logic [31:0] win_r    [16];
  logic [31:0] frm_r    [16];
  logic [15:0] pos_r;
  logic [35:0] acc_r;
  logic [3:0]  idx_r;
  logic [35:0] lane_sum_s;
  logic [35:0] acc_next_s;
  state_t      state_r, state_n;
  logic        accept_s;
  logic        finish_s;

  assign window_s[0]  = Window0;  assign window_s[1]  = Window1;
  assign window_s[2]  = Window2;  assign window_s[3]  = Window3;
  assign window_s[4]  = Window4;  assign window_s[5]  = Window5;
  assign window_s[6]  = Window6;  assign window_s[7]  = Window7;
  assign window_s[8]  = Window8;  assign window_s[9]  = Window9;
  assign window_s[10] = Window10; assign window_s[11] = Window11;
  assign window_s[12] = Window12; assign window_s[13] = Window13;
  assign window_s[14] = Window14; assign window_s[15] = Window15;
  assign frame_s[0]   = Frame0;   assign frame_s[1]   = Frame1;
  assign frame_s[2]   = Frame2;   assign frame_s[3]   = Frame3;
  assign frame_s[4]   = Frame4;   assign frame_s[5]   = Frame5;
  assign frame_s[6]   = Frame6;   assign frame_s[7]   = Frame7;
  assign frame_s[8]   = Frame8;   assign frame_s[9]   = Frame9;
  assign frame_s[10]  = Frame10;  assign frame_s[11]  = Frame11;
  assign frame_s[12]  = Frame12;  assign frame_s[13]  = Frame13;
  assign frame_s[14]  = Frame14;  assign frame_s[15]  = Frame15;

  // Next-state logic; Start is honoured in DONE so jobs can run back-to-back.
  always_comb begin
    state_n  = state_r;
    accept_s = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          state_n  = ST_ACCUM;
          accept_s = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (idx_r == LAST_IDX) begin
          state_n  = ST_DONE;
          finish_s = 1'b1;
        end else begin
          state_n = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (Start) begin
          state_n  = ST_ACCUM;
          accept_s = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Sum of the LANES element differences handled this cycle.
  always_comb begin
    lane_sum_s = 36'd0;
    for (int l = 0; l < LANES; l++) begin
      lane_sum_s = lane_sum_s + {4'd0, abs_diff(win_r[idx_r + 4'(l)], frm_r[idx_r + 4'(l)])};
    end
    acc_next_s = acc_r + lane_sum_s;
  end

  // State register with registered Busy/Done decoded from the next state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state_r <= state_n;
      Busy    <= (state_n == ST_ACCUM);
      Done    <= (state_n == ST_DONE);
    end
  end

  // Operand snapshot, accumulator and result register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) begin
        win_r[i] <= 32'd0;
        frm_r[i] <= 32'd0;
      end
      pos_r    <= 16'd0;
      acc_r    <= 36'd0;
      idx_r    <= 4'd0;
      SadValue <= 36'd0;
    end else begin
      if (accept_s) begin
        for (int i = 0; i < 16; i++) begin
          win_r[i] <= window_s[i];
          frm_r[i] <= frame_s[i];
        end
        pos_r <= Position;
        acc_r <= 36'd0;
        idx_r <= 4'd0;
      end else if (state_r == ST_ACCUM) begin
        acc_r <= acc_next_s;
        idx_r <= idx_r + STEP;
      end else begin
        acc_r <= acc_r;
        idx_r <= idx_r;
      end
      if (finish_s) begin
        SadValue <= acc_next_s;
      end else begin
        SadValue <= SadValue;
      end
    end
  end

  // Best-match tracking. A ClearBest on a result edge clears first, so the
  // new result is then recorded unconditionally. Ties keep the older entry.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      BestSad   <= SAD_MAX;
      BestPos   <= 16'd0;
      BestValid <= 1'b0;
    end else if (finish_s && (ClearBest || !BestValid || (acc_next_s < BestSad))) begin
      BestSad   <= acc_next_s;
      BestPos   <= pos_r;
      BestValid <= 1'b1;
    end else if (ClearBest) begin
      BestSad   <= SAD_MAX;
      BestPos   <= 16'd0;
      BestValid <= 1'b0;
    end else begin
      BestSad   <= BestSad;
      BestPos   <= BestPos;
      BestValid <= BestValid;
    end
  end

endmodule

// File: tb/tb_sad_engine.sv
// Self-checking bench for sad_engine: three instances (LANES 4, 1, 16) share
// the same inputs; the LANES=4 instance carries the table, corner and
// randomized checks against a plain-arithmetic reference model.
module tb_sad_engine;

  logic        clk = 1'b0;
  logic        reset, start, clear;
  logic [15:0] pos;
  logic [31:0] win [16];
  logic [31:0] frm [16];

  logic        busy4, done4, bval4, busy1, done1, bval1, busy16, done16, bval16;
  logic [35:0] sad4, bsad4, sad1, bsad1, sad16, bsad16;
  logic [15:0] bpos4, bpos1, bpos16;

  int total = 0;
  int bad   = 0;

  logic [35:0] m_best;
  logic [15:0] m_pos;
  logic        m_valid;

  always #5 clk = ~clk;

  sad_engine #(.LANES(4)) dut4 (
    .Clk(clk), .Reset(reset), .Start(start), .Position(pos), .ClearBest(clear),
    .Window0(win[0]), .Window1(win[1]), .Window2(win[2]), .Window3(win[3]),
    .Window4(win[4]), .Window5(win[5]), .Window6(win[6]), .Window7(win[7]),
    .Window8(win[8]), .Window9(win[9]), .Window10(win[10]), .Window11(win[11]),
    .Window12(win[12]), .Window13(win[13]), .Window14(win[14]), .Window15(win[15]),
    .Frame0(frm[0]), .Frame1(frm[1]), .Frame2(frm[2]), .Frame3(frm[3]),
    .Frame4(frm[4]), .Frame5(frm[5]), .Frame6(frm[6]), .Frame7(frm[7]),
    .Frame8(frm[8]), .Frame9(frm[9]), .Frame10(frm[10]), .Frame11(frm[11]),
    .Frame12(frm[12]), .Frame13(frm[13]), .Frame14(frm[14]), .Frame15(frm[15]),
    .Busy(busy4), .Done(done4), .SadValue(sad4), .BestSad(bsad4), .BestPos(bpos4),
    .BestValid(bval4));

  sad_engine #(.LANES(1)) dut1 (
    .Clk(clk), .Reset(reset), .Start(start), .Position(pos), .ClearBest(clear),
    .Window0(win[0]), .Window1(win[1]), .Window2(win[2]), .Window3(win[3]),
    .Window4(win[4]), .Window5(win[5]), .Window6(win[6]), .Window7(win[7]),
    .Window8(win[8]), .Window9(win[9]), .Window10(win[10]), .Window11(win[11]),
    .Window12(win[12]), .Window13(win[13]), .Window14(win[14]), .Window15(win[15]),
    .Frame0(frm[0]), .Frame1(frm[1]), .Frame2(frm[2]), .Frame3(frm[3]),
    .Frame4(frm[4]), .Frame5(frm[5]), .Frame6(frm[6]), .Frame7(frm[7]),
    .Frame8(frm[8]), .Frame9(frm[9]), .Frame10(frm[10]), .Frame11(frm[11]),
    .Frame12(frm[12]), .Frame13(frm[13]), .Frame14(frm[14]), .Frame15(frm[15]),
    .Busy(busy1), .Done(done1), .SadValue(sad1), .BestSad(bsad1), .BestPos(bpos1),
    .BestValid(bval1));

  sad_engine #(.LANES(16)) dut16 (
    .Clk(clk), .Reset(reset), .Start(start), .Position(pos), .ClearBest(clear),
    .Window0(win[0]), .Window1(win[1]), .Window2(win[2]), .Window3(win[3]),
    .Window4(win[4]), .Window5(win[5]), .Window6(win[6]), .Window7(win[7]),
    .Window8(win[8]), .Window9(win[9]), .Window10(win[10]), .Window11(win[11]),
    .Window12(win[12]), .Window13(win[13]), .Window14(win[14]), .Window15(win[15]),
    .Frame0(frm[0]), .Frame1(frm[1]), .Frame2(frm[2]), .Frame3(frm[3]),
    .Frame4(frm[4]), .Frame5(frm[5]), .Frame6(frm[6]), .Frame7(frm[7]),
    .Frame8(frm[8]), .Frame9(frm[9]), .Frame10(frm[10]), .Frame11(frm[11]),
    .Frame12(frm[12]), .Frame13(frm[13]), .Frame14(frm[14]), .Frame15(frm[15]),
    .Busy(busy16), .Done(done16), .SadValue(sad16), .BestSad(bsad16), .BestPos(bpos16),
    .BestValid(bval16));

  typedef struct {
    logic [31:0] w0;
    logic [31:0] wr;
    logic [31:0] f;
    logic [15:0] p;
    logic        clr;
    logic [35:0] e_sad;
    logic [35:0] e_best;
    logic [15:0] e_pos;
  } vec_t;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ops(input logic [31:0] w0, input logic [31:0] wr, input logic [31:0] f);
    win[0] = w0;
    for (int i = 1; i < 16; i++) win[i] = wr;
    for (int i = 0; i < 16; i++) frm[i] = f;
  endtask

  // Reference SAD straight from the definition.
  function automatic logic [35:0] ref_sad();
    logic [35:0] s;
    s = 36'd0;
    for (int i = 0; i < 16; i++) begin
      if (win[i] > frm[i]) s = s + 36'(win[i] - frm[i]);
      else                 s = s + 36'(frm[i] - win[i]);
    end
    return s;
  endfunction

  task automatic model_clear;
    m_best  = 36'hF_FFFF_FFFF;
    m_pos   = 16'd0;
    m_valid = 1'b0;
  endtask

  task automatic model_result(input logic [35:0] s, input logic [15:0] p);
    if (!m_valid || s < m_best) begin
      m_best  = s;
      m_pos   = p;
      m_valid = 1'b1;
    end
  endtask

  // Issue one job on the LANES=4 instance and wait (bounded) for its Done.
  task automatic run_job(input logic [15:0] p, input logic clr,
                         output logic [35:0] s, output int lat);
    pos   = p;
    start = 1'b1;
    clear = clr;
    tick();
    start = 1'b0;
    clear = 1'b0;
    lat   = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (done4) begin
        lat = n;
        break;
      end
    end
    s = sad4;
    if (lat < 0) begin
      total++;
      bad++;
      $display("FAIL job_timeout: got no Done expected Done within 40 cycles");
    end
  endtask

  initial begin
    vec_t        tbl [7];
    logic [35:0] s, exp;
    int          lat, dcount, first, lat1, lat4, lat16;
    logic [35:0] s1, s4, s16;
    logic [15:0] p;
    logic        clr;

    tbl[0] = '{32'd5, 32'd5, 32'd3, 16'd7, 1'b0, 36'd32, 36'd32, 16'd7};
    tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 16'd8, 1'b0, 36'hF_FFFF_FFF0, 36'd32, 16'd7};
    tbl[2] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 16'd9, 1'b0, 36'hF_FFFF_FFF0, 36'd32, 16'd7};
    tbl[3] = '{32'd100, 32'd0, 32'd0, 16'd1, 1'b1, 36'd100, 36'd100, 16'd1};
    tbl[4] = '{32'd40, 32'd0, 32'd0, 16'd2, 1'b0, 36'd40, 36'd40, 16'd2};
    tbl[5] = '{32'd40, 32'd0, 32'd0, 16'd3, 1'b0, 36'd40, 36'd40, 16'd2};
    tbl[6] = '{32'd90, 32'd0, 32'd0, 16'd4, 1'b0, 36'd90, 36'd40, 16'd2};

    reset = 1'b1; start = 1'b0; clear = 1'b0; pos = 16'd0;
    set_ops(32'd0, 32'd0, 32'd0);
    tick(); tick();
    reset = 1'b0;
    check("rst_busy", 36'(busy4), 36'd0);
    check("rst_done", 36'(done4), 36'd0);
    check("rst_sad", sad4, 36'd0);
    check("rst_best", bsad4, 36'hF_FFFF_FFFF);
    check("rst_pos", 36'(bpos4), 36'd0);
    check("rst_valid", 36'(bval4), 36'd0);
    tick();

    // Table jobs run back-to-back: each new Start lands in the Done cycle.
    for (int i = 0; i < 7; i++) begin
      set_ops(tbl[i].w0, tbl[i].wr, tbl[i].f);
      run_job(tbl[i].p, tbl[i].clr, s, lat);
      check($sformatf("tbl%0d_sad", i), s, tbl[i].e_sad);
      check($sformatf("tbl%0d_lat", i), 36'(lat), 36'd4);
      check($sformatf("tbl%0d_busy", i), 36'(busy4), 36'd0);
      check($sformatf("tbl%0d_best", i), bsad4, tbl[i].e_best);
      check($sformatf("tbl%0d_pos", i), 36'(bpos4), 36'(tbl[i].e_pos));
      check($sformatf("tbl%0d_valid", i), 36'(bval4), 36'd1);
    end

    // Mixed pairs (10,3),(3,10),(0,0)...
    set_ops(32'd0, 32'd0, 32'd0);
    win[0] = 32'd10; frm[0] = 32'd3;
    win[1] = 32'd3;  frm[1] = 32'd10;
    run_job(16'd11, 1'b0, s, lat);
    check("mixed_sad", s, 36'd14);

    // ClearBest alone.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_valid", 36'(bval4), 36'd0);
    check("clr_best", bsad4, 36'hF_FFFF_FFFF);
    check("clr_pos", 36'(bpos4), 36'd0);

    // Snapshot: operands/Position change right after acceptance, plus a
    // second Start while busy that must be ignored.
    set_ops(32'd7, 32'd7, 32'd2);
    pos = 16'd21; start = 1'b1;
    tick();
    start = 1'b0;
    set_ops(32'd1000, 32'd0, 32'd0);
    pos = 16'd99;
    dcount = 0; first = -1;
    for (int n = 1; n <= 14; n++) begin
      tick();
      if (done4) begin
        dcount++;
        if (first < 0) begin
          first = n;
          check("snap_sad", sad4, 36'd80);
          check("snap_pos", 36'(bpos4), 36'd21);
        end
      end
      start = (n == 1);
    end
    start = 1'b0;
    check("snap_lat", 36'(first), 36'd4);
    check("busy_start_dones", 36'(dcount), 36'd1);

    // Reset during the second accumulate cycle aborts the job.
    set_ops(32'd9, 32'd1, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 36'(busy4), 36'd0);
    check("abort_done", 36'(done4), 36'd0);
    check("abort_sad", sad4, 36'd0);
    check("abort_best", bsad4, 36'hF_FFFF_FFFF);
    check("abort_pos", 36'(bpos4), 36'd0);
    check("abort_valid", 36'(bval4), 36'd0);
    dcount = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (done4) dcount++;
    end
    check("abort_no_done", 36'(dcount), 36'd0);

    // ClearBest on the result edge: clear first, then record 55/pos 9.
    set_ops(32'd20, 32'd0, 32'd0);
    run_job(16'd5, 1'b0, s, lat);
    check("pre_best", bsad4, 36'd20);
    tick();
    set_ops(32'd55, 32'd0, 32'd0);
    pos = 16'd9; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("coll_done", 36'(done4), 36'd1);
    check("coll_sad", sad4, 36'd55);
    check("coll_best", bsad4, 36'd55);
    check("coll_pos", 36'(bpos4), 36'd9);
    check("coll_valid", 36'(bval4), 36'd1);

    // Randomized jobs against the reference model.
    for (int i = 0; i < 24; i++) begin
      int mode;
      mode = $urandom_range(0, 2);
      for (int j = 0; j < 16; j++) begin
        if (mode == 0) begin
          win[j] = $urandom_range(0, 255);
          frm[j] = $urandom_range(0, 255);
        end else if (mode == 1) begin
          win[j] = $urandom;
          frm[j] = $urandom;
        end else begin
          win[j] = $urandom;
          frm[j] = win[j] ^ 32'($urandom_range(0, 3));
        end
      end
      p   = 16'($urandom);
      clr = (i == 0) || ($urandom_range(0, 7) == 0);
      exp = ref_sad();
      run_job(p, clr, s, lat);
      if (clr) model_clear();
      model_result(exp, p);
      check($sformatf("rnd%0d_sad", i), s, exp);
      check($sformatf("rnd%0d_lat", i), 36'(lat), 36'd4);
      check($sformatf("rnd%0d_best", i), bsad4, m_best);
      check($sformatf("rnd%0d_pos", i), 36'(bpos4), 36'(m_pos));
      check($sformatf("rnd%0d_valid", i), 36'(bval4), 36'(m_valid));
    end

    // Lane-count builds: same SAD, latency 16/LANES.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int j = 0; j < 16; j++) begin
      win[j] = $urandom;
      frm[j] = $urandom;
    end
    exp = ref_sad();
    pos = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    lat1 = -1; lat4 = -1; lat16 = -1;
    s1 = 36'd0; s4 = 36'd0; s16 = 36'd0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (done1 && lat1 < 0)   begin lat1 = n;  s1 = sad1;   end
      if (done4 && lat4 < 0)   begin lat4 = n;  s4 = sad4;   end
      if (done16 && lat16 < 0) begin lat16 = n; s16 = sad16; end
    end
    check("l1_lat", 36'(lat1), 36'd16);
    check("l4_lat", 36'(lat4), 36'd4);
    check("l16_lat", 36'(lat16), 36'd1);
    check("l1_sad", s1, exp);
    check("l4_sad", s4, exp);
    check("l16_sad", s16, exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
